// File: rtl/video_timing_gen.sv
// Reconfigurable raster timing generator: pixel/line counters, sync/active/new-frame
// decodes and a frame counter, with a one-deep shadow config applied only at frame end.
module video_timing_gen #(
    parameter int HW      = 12,
    parameter int VW      = 11,
    parameter int FCW     = 6,
    parameter int FPS     = 60,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1,
    parameter int RST_HA  = 1280,
    parameter int RST_HFP = 110,
    parameter int RST_HSW = 40,
    parameter int RST_HBP = 220,
    parameter int RST_VA  = 720,
    parameter int RST_VFP = 5,
    parameter int RST_VSW = 5,
    parameter int RST_VBP = 20
) (
    input  logic           pixel_clk_in,
    input  logic           rst_in,
    input  logic           cfg_valid_in,
    output logic           cfg_ready_out,
    input  logic [HW-1:0]  cfg_h_active_in,
    input  logic [HW-1:0]  cfg_h_fp_in,
    input  logic [HW-1:0]  cfg_h_sync_in,
    input  logic [HW-1:0]  cfg_h_bp_in,
    input  logic [VW-1:0]  cfg_v_active_in,
    input  logic [VW-1:0]  cfg_v_fp_in,
    input  logic [VW-1:0]  cfg_v_sync_in,
    input  logic [VW-1:0]  cfg_v_bp_in,
    output logic           cfg_pending_out,
    output logic           cfg_err_out,
    output logic [HW-1:0]  hcount_out,
    output logic [VW-1:0]  vcount_out,
    output logic           hs_out,
    output logic           vs_out,
    output logic           ad_out,
    output logic           nf_out,
    output logic [FCW-1:0] fc_out
);
    localparam logic [3:0][HW-1:0] H_RST = {HW'(RST_HBP), HW'(RST_HSW), HW'(RST_HFP), HW'(RST_HA)};
    localparam logic [3:0][VW-1:0] V_RST = {VW'(RST_VBP), VW'(RST_VSW), VW'(RST_VFP), VW'(RST_VA)};
    localparam logic [HW+1:0]  H_LIMIT = (HW+2)'(2**HW);
    localparam logic [VW+1:0]  V_LIMIT = (VW+2)'(2**VW);
    localparam logic [HW:0]    H_ONE   = (HW+1)'(1);
    localparam logic [VW:0]    V_ONE   = (VW+1)'(1);
    localparam logic [FCW-1:0] FC_MAX  = FCW'(FPS - 1);
    localparam logic           HS_ACT  = (HS_POL != 0);
    localparam logic           VS_ACT  = (VS_POL != 0);

    // Field index order everywhere: 0 active, 1 front porch, 2 sync, 3 back porch.
    logic [3:0][HW-1:0] cfg_h, h_work_reg, h_shadow_reg;
    logic [3:0][VW-1:0] cfg_v, v_work_reg, v_shadow_reg;
    logic [HW-1:0]      hcount_reg, hcount_next;
    logic [VW-1:0]      vcount_reg, vcount_next;
    logic [FCW-1:0]     fc_reg;
    logic               pending_reg, err_reg;

    logic [3:0]         h_nz, v_nz;
    logic [HW+1:0]      cfg_ht_wide;
    logic [VW+1:0]      cfg_vt_wide;
    logic               cfg_ok, xfer;
    logic [HW:0]        ht, hs_lo, hs_hi, hc_ext;
    logic [VW:0]        vt, vs_lo, vs_hi, vc_ext;
    logic               h_last, v_last, h_sync_region, v_sync_region;

    assign cfg_h = {cfg_h_bp_in, cfg_h_sync_in, cfg_h_fp_in, cfg_h_active_in};
    assign cfg_v = {cfg_v_bp_in, cfg_v_sync_in, cfg_v_fp_in, cfg_v_active_in};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nz
            assign h_nz[gi] = |cfg_h[gi];
            assign v_nz[gi] = |cfg_v[gi];
        end
    endgenerate

    // Validation sums carry two extra bits so four maximal fields cannot wrap.
    assign cfg_ht_wide = (HW+2)'(cfg_h[0]) + (HW+2)'(cfg_h[1]) + (HW+2)'(cfg_h[2]) + (HW+2)'(cfg_h[3]);
    assign cfg_vt_wide = (VW+2)'(cfg_v[0]) + (VW+2)'(cfg_v[1]) + (VW+2)'(cfg_v[2]) + (VW+2)'(cfg_v[3]);
    assign cfg_ok = (&h_nz) & (&v_nz) & (cfg_ht_wide <= H_LIMIT) & (cfg_vt_wide <= V_LIMIT);
    assign xfer   = cfg_valid_in & ~pending_reg;

    assign ht = (HW+1)'(h_work_reg[0]) + (HW+1)'(h_work_reg[1]) + (HW+1)'(h_work_reg[2]) + (HW+1)'(h_work_reg[3]);
    assign vt = (VW+1)'(v_work_reg[0]) + (VW+1)'(v_work_reg[1]) + (VW+1)'(v_work_reg[2]) + (VW+1)'(v_work_reg[3]);

    assign hc_ext = {1'b0, hcount_reg};
    assign vc_ext = {1'b0, vcount_reg};
    assign h_last = (hc_ext == ht - H_ONE);
    assign v_last = (vc_ext == vt - V_ONE);

    assign hs_lo = {1'b0, h_work_reg[0]} + {1'b0, h_work_reg[1]};
    assign hs_hi = hs_lo + {1'b0, h_work_reg[2]};
    assign vs_lo = {1'b0, v_work_reg[0]} + {1'b0, v_work_reg[1]};
    assign vs_hi = vs_lo + {1'b0, v_work_reg[2]};
    assign h_sync_region = (hc_ext >= hs_lo) & (hc_ext < hs_hi);
    assign v_sync_region = (vc_ext >= vs_lo) & (vc_ext < vs_hi);

    assign hs_out = (h_sync_region & ~rst_in) ? HS_ACT : ~HS_ACT;
    assign vs_out = (v_sync_region & ~rst_in) ? VS_ACT : ~VS_ACT;
    assign ad_out = ~rst_in & (hcount_reg < h_work_reg[0]) & (vcount_reg < v_work_reg[0]);
    assign nf_out = ~rst_in & (hcount_reg == h_work_reg[0]) & (vcount_reg == v_work_reg[0]);

    assign hcount_out      = hcount_reg;
    assign vcount_out      = vcount_reg;
    assign fc_out          = fc_reg;
    assign cfg_pending_out = pending_reg;
    assign cfg_ready_out   = ~pending_reg;
    assign cfg_err_out     = err_reg;

    always_comb begin
        hcount_next = hcount_reg + HW'(1);
        vcount_next = vcount_reg;
        if (h_last) begin
            hcount_next = '0;
            vcount_next = v_last ? '0 : vcount_reg + VW'(1);
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_reg   <= '0;
            vcount_reg   <= '0;
            fc_reg       <= '0;
            h_work_reg   <= H_RST;
            v_work_reg   <= V_RST;
            h_shadow_reg <= '0;
            v_shadow_reg <= '0;
            pending_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
            err_reg    <= xfer & ~cfg_ok;
            if (nf_out)
                fc_reg <= (fc_reg == FC_MAX) ? '0 : fc_reg + FCW'(1);
            // Accept and apply are exclusive: accept needs pending=0, apply needs pending=1.
            if (xfer & cfg_ok) begin
                h_shadow_reg <= cfg_h;
                v_shadow_reg <= cfg_v;
                pending_reg  <= 1'b1;
            end
            if (h_last & v_last & pending_reg) begin
                h_work_reg  <= h_shadow_reg;
                v_work_reg  <= v_shadow_reg;
                pending_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a frame-position reference model queues the expected outputs of
// every cycle; a monitor pops and compares them against the DUT on the falling edge.
module tb_video_timing_gen;
    localparam int HW = 12, VW = 11, FCW = 6, FPS = 3, HS_POL = 0, VS_POL = 1;
    localparam int RHA = 20, RHFP = 3, RHSW = 4, RHBP = 5;
    localparam int RVA = 10, RVFP = 2, RVSW = 3, RVBP = 4;

    logic           clk = 1'b0;
    logic           rst_in = 1'b1;
    logic           cfg_valid_in = 1'b0;
    logic           cfg_ready_out, cfg_pending_out, cfg_err_out;
    logic [HW-1:0]  cfg_h_active_in = '0, cfg_h_fp_in = '0, cfg_h_sync_in = '0, cfg_h_bp_in = '0;
    logic [VW-1:0]  cfg_v_active_in = '0, cfg_v_fp_in = '0, cfg_v_sync_in = '0, cfg_v_bp_in = '0;
    logic [HW-1:0]  hcount_out;
    logic [VW-1:0]  vcount_out;
    logic           hs_out, vs_out, ad_out, nf_out;
    logic [FCW-1:0] fc_out;

    always #5 clk = ~clk;

    video_timing_gen #(
        .HW(HW), .VW(VW), .FCW(FCW), .FPS(FPS), .HS_POL(HS_POL), .VS_POL(VS_POL),
        .RST_HA(RHA), .RST_HFP(RHFP), .RST_HSW(RHSW), .RST_HBP(RHBP),
        .RST_VA(RVA), .RST_VFP(RVFP), .RST_VSW(RVSW), .RST_VBP(RVBP)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst_in),
        .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
        .cfg_h_active_in(cfg_h_active_in), .cfg_h_fp_in(cfg_h_fp_in),
        .cfg_h_sync_in(cfg_h_sync_in), .cfg_h_bp_in(cfg_h_bp_in),
        .cfg_v_active_in(cfg_v_active_in), .cfg_v_fp_in(cfg_v_fp_in),
        .cfg_v_sync_in(cfg_v_sync_in), .cfg_v_bp_in(cfg_v_bp_in),
        .cfg_pending_out(cfg_pending_out), .cfg_err_out(cfg_err_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out), .nf_out(nf_out), .fc_out(fc_out)
    );

    typedef struct { int ha, hfp, hsw, hbp, va, vfp, vsw, vbp; } cfg_t;
    typedef struct packed {
        logic [HW-1:0] hc; logic [VW-1:0] vc;
        logic hs, vs, ad, nf; logic [FCW-1:0] fc;
        logic rdy, pend, err;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0, bad = 0;

    // Reference state: linear position inside the frame plus the config registers.
    cfg_t m_work, m_shadow;
    int   m_pos, m_fc;
    bit   m_pending, m_err;

    function automatic int ht_of(cfg_t c); return c.ha + c.hfp + c.hsw + c.hbp; endfunction
    function automatic int vt_of(cfg_t c); return c.va + c.vfp + c.vsw + c.vbp; endfunction
    function automatic int frame_of(cfg_t c); return ht_of(c) * vt_of(c); endfunction

    function automatic bit legal(cfg_t c);
        if (c.ha == 0 || c.hfp == 0 || c.hsw == 0 || c.hbp == 0) return 0;
        if (c.va == 0 || c.vfp == 0 || c.vsw == 0 || c.vbp == 0) return 0;
        return (ht_of(c) <= 2**HW) && (vt_of(c) <= 2**VW);
    endfunction

    function automatic cfg_t mk(int a, int b, int c, int d, int e, int f, int g, int h);
        cfg_t r;
        r.ha = a; r.hfp = b; r.hsw = c; r.hbp = d; r.va = e; r.vfp = f; r.vsw = g; r.vbp = h;
        return r;
    endfunction

    function automatic cfg_t offered();
        return mk(int'(cfg_h_active_in), int'(cfg_h_fp_in), int'(cfg_h_sync_in), int'(cfg_h_bp_in),
                  int'(cfg_v_active_in), int'(cfg_v_fp_in), int'(cfg_v_sync_in), int'(cfg_v_bp_in));
    endfunction

    task automatic model_reset();
        m_work = mk(RHA, RHFP, RHSW, RHBP, RVA, RVFP, RVSW, RVBP);
        m_shadow = mk(0, 0, 0, 0, 0, 0, 0, 0);
        m_pos = 0; m_fc = 0; m_pending = 0; m_err = 0;
    endtask

    task automatic model_step();
        cfg_t c = offered();
        bit   was_pending = m_pending;
        int   frame = frame_of(m_work);
        int   h = m_pos % ht_of(m_work);
        int   v = m_pos / ht_of(m_work);
        if (h == m_work.ha && v == m_work.va) m_fc = (m_fc + 1) % FPS;
        m_err = 0;
        if (cfg_valid_in && !was_pending) begin
            if (legal(c)) begin
                m_shadow = c; m_pending = 1;
                $display("t=%0t cfg accept H %0d/%0d/%0d/%0d V %0d/%0d/%0d/%0d", $time,
                         c.ha, c.hfp, c.hsw, c.hbp, c.va, c.vfp, c.vsw, c.vbp);
            end else begin
                m_err = 1;
                $display("t=%0t cfg reject H %0d/%0d/%0d/%0d V %0d/%0d/%0d/%0d", $time,
                         c.ha, c.hfp, c.hsw, c.hbp, c.va, c.vfp, c.vsw, c.vbp);
            end
        end
        if (m_pos == frame - 1) begin
            m_pos = 0;
            if (was_pending) begin
                m_work = m_shadow; m_pending = 0;
                $display("t=%0t cfg apply  HT=%0d VT=%0d", $time, ht_of(m_work), vt_of(m_work));
            end
        end else begin
            m_pos++;
        end
    endtask

    function automatic obs_t model_expect();
        obs_t e;
        int   h = m_pos % ht_of(m_work);
        int   v = m_pos / ht_of(m_work);
        bit   hreg = (h >= m_work.ha + m_work.hfp) && (h < m_work.ha + m_work.hfp + m_work.hsw);
        bit   vreg = (v >= m_work.va + m_work.vfp) && (v < m_work.va + m_work.vfp + m_work.vsw);
        e.hc   = HW'(h);
        e.vc   = VW'(v);
        e.hs   = (hreg && !rst_in) ? (HS_POL != 0) : (HS_POL == 0);
        e.vs   = (vreg && !rst_in) ? (VS_POL != 0) : (VS_POL == 0);
        e.ad   = !rst_in && h < m_work.ha && v < m_work.va;
        e.nf   = !rst_in && h == m_work.ha && v == m_work.va;
        e.fc   = FCW'(m_fc);
        e.rdy  = !m_pending;
        e.pend = m_pending;
        e.err  = m_err;
        return e;
    endfunction

    // Model: step on the rising edge, account for any reset driven mid-cycle, then queue.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_in) model_step();
            #3;
            if (rst_in) model_reset();
            exp_q.push_back(model_expect());
        end
    end

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            a = {hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
                 cfg_ready_out, cfg_pending_out, cfg_err_out};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL outputs t=%0t got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d rdy=%b pend=%b err=%b want h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d rdy=%b pend=%b err=%b",
                                 $time, a.hc, a.vc, a.hs, a.vs, a.ad, a.nf, a.fc, a.rdy, a.pend, a.err,
                                 e.hc, e.vc, e.hs, e.vs, e.ad, e.nf, e.fc, e.rdy, e.pend, e.err);
                end
            end
        end
    end

    task automatic tick(); @(posedge clk); #2; endtask

    task automatic offer(cfg_t c, int cycles);
        cfg_h_active_in = HW'(c.ha); cfg_h_fp_in = HW'(c.hfp); cfg_h_sync_in = HW'(c.hsw); cfg_h_bp_in = HW'(c.hbp);
        cfg_v_active_in = VW'(c.va); cfg_v_fp_in = VW'(c.vfp); cfg_v_sync_in = VW'(c.vsw); cfg_v_bp_in = VW'(c.vbp);
        cfg_valid_in = 1'b1;
        repeat (cycles) tick();
        cfg_valid_in = 1'b0;
    endtask

    task automatic wait_applied(int limit);
        int n = 0;
        while (m_pending && n < limit) begin tick(); n++; end
        if (m_pending) begin
            total++; bad++;
            $display("FAIL apply_timeout waited=%0d cycles, required pending=0", n);
        end
    endtask

    task automatic wait_frame_end(int limit);
        int n = 0;
        while (m_pos != frame_of(m_work) - 1 && n < limit) begin tick(); n++; end
        if (m_pos != frame_of(m_work) - 1) begin
            total++; bad++;
            $display("FAIL frame_end_timeout pos=%0d required=%0d", m_pos, frame_of(m_work) - 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t small_c, a_c, b_c;
        small_c = mk(8, 2, 2, 2, 4, 1, 1, 1);
        a_c     = mk(10, 2, 3, 1, 5, 1, 2, 1);
        b_c     = mk(6, 1, 1, 1, 3, 1, 1, 1);

        repeat (3) tick();
        rst_in = 1'b0;
        // Reset timing for four frames: fc walks 0,1,2,0 with FPS=3.
        repeat (4 * frame_of(mk(RHA, RHFP, RHSW, RHBP, RVA, RVFP, RVSW, RVBP)) + 20) tick();

        offer(small_c, 1);
        wait_applied(2000);
        repeat (3 * 98) tick();

        // Rejects: zero sync width, HT = 4097, and back-to-back bad offers.
        offer(mk(8, 2, 0, 2, 4, 1, 1, 1), 1);
        repeat (3) tick();
        offer(mk(4000, 50, 40, 7, 4, 1, 1, 1), 3);
        offer(mk(8, 2, 2, 2, 4, 0, 1, 1), 2);
        repeat (40) tick();

        // Back-pressure: second offer while pending is not captured.
        offer(a_c, 1);
        tick();
        offer(b_c, 5);
        wait_applied(2000);
        repeat (2 * frame_of(a_c)) tick();

        // Offer on the last cycle of a frame with nothing pending: applied one frame later.
        wait_frame_end(2000);
        offer(b_c, 1);
        wait_applied(2000);
        repeat (frame_of(b_c) + 5) tick();

        // Reset while a config is pending: the shadow is discarded.
        offer(small_c, 1);
        repeat (5) tick();
        rst_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b0;
        repeat (frame_of(mk(RHA, RHFP, RHSW, RHBP, RVA, RVFP, RVSW, RVBP)) + 30) tick();

        // Randomized offers, including illegal ones and occasional resets.
        for (int i = 0; i < 30; i++) begin
            cfg_t r = mk($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
                         $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 4) == 0) r.hsw = 0;
            if ($urandom_range(0, 7) == 0) r.vbp = 0;
            if ($urandom_range(0, 7) == 0) r.ha = 4095;
            offer(r, $urandom_range(1, 3));
            repeat ($urandom_range(0, 150)) tick();
            if ($urandom_range(0, 9) == 0) begin
                rst_in = 1'b1;
                tick();
                rst_in = 1'b0;
            end
        end
        wait_applied(5000);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
